// File: rtl/dram_responder_pkg.sv
// Shared types for the data-RAM responder: data width, strobe width and the
// response entry that travels through the read-data FIFO.
// Optional build macro: DRAM_RANGE_CHK_EN adds an error bit to each response.
package dram_responder_pkg;

  localparam int XLEN        = 32;
  localparam int DRAM_STRB_W = XLEN / 8;

  // One read response as stored in the FIFO; err only exists with range checking.
  typedef struct packed {
`ifdef DRAM_RANGE_CHK_EN
    logic            err;
`endif
    logic [XLEN-1:0] rdata;
  } dram_resp_t;

endpackage

// File: rtl/dram_responder_sync_fifo.sv
// sync_fifo: single-clock FIFO of WIDTH-bit entries, any DEPTH >= 1.
// A push into a full FIFO is accepted only when a pop frees a slot in the same
// cycle; a pop of an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // Entry storage; only the valid window between the pointers is ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_responder.sv
// dram_responder: slave side of the core's data-RAM request interface.
// Writes are byte-strobed into a word-addressed array and never respond.
// Reads sample the array in the acceptance cycle, travel LATENCY-1 delay
// stages and queue in a response FIFO popped by data_ok & rready. A registered
// credit counter bounds reads in flight to OUTSTANDING so the FIFO never
// overflows.
// Optional build macro: DRAM_RANGE_CHK_EN -- requests at or above DEPTH*4 drop
// writes and answer reads with rdata=0, dram_err=1; without it the upper
// address bits simply wrap onto the array.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   dram_req,
  input  logic                   dram_write,
  input  logic [DRAM_STRB_W-1:0] dram_wstrb,
  input  logic [XLEN-1:0]        dram_addr,
  input  logic [XLEN-1:0]        dram_wdata,
  output logic                   dram_addr_ok,
  output logic                   dram_data_ok,
  output logic [XLEN-1:0]        dram_rdata,
  input  logic                   dram_rready
`ifdef DRAM_RANGE_CHK_EN
  ,
  output logic                   dram_err
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [AW-1:0]    word_idx;
  logic [CNT_W-1:0] cnt;
  logic             rd_acc;
  logic             wr_acc;
  logic             wr_en;
  logic             pop;
  logic             push_vld;
  logic             fifo_empty;
  logic             unused_fifo_full;
  logic             unused_addr;
  dram_resp_t       rd_word;
  dram_resp_t       push_data;
  dram_resp_t       head;
  logic [XLEN-1:0]  hold_q;

  assign word_idx = dram_addr[AW+1:2];

`ifdef DRAM_RANGE_CHK_EN
  logic out_of_range;
  assign out_of_range = |dram_addr[XLEN-1:AW+2];
  assign wr_en        = wr_acc & ~out_of_range;
  assign unused_addr  = ^dram_addr[1:0];
`else
  assign wr_en        = wr_acc;
  assign unused_addr  = ^{dram_addr[XLEN-1:AW+2], dram_addr[1:0]};
`endif

  // Writes are always taken; reads need a free credit. The credit is the
  // registered count, so a pop only opens a slot from the following cycle.
  // Nothing is taken while reset is held.
  assign dram_addr_ok = rst_b & dram_req & (dram_write | (cnt < CNT_W'(OUTSTANDING)));
  assign wr_acc       = dram_addr_ok & dram_write;
  assign rd_acc       = dram_addr_ok & ~dram_write;

  // NOTE: the data array has no reset branch -- its contents must survive
  // rst_b, and a reset would also stop the tools mapping it onto a RAM.
  // Byte-strobed write at the end of the acceptance cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DRAM_STRB_W; i++) begin
        if (dram_wstrb[i]) mem[word_idx][8*i +: 8] <= dram_wdata[8*i +: 8];
      end
    end
  end

  // Word seen by a read accepted this cycle (pre-write value of the array).
  always_comb begin
    rd_word       = '0;
    rd_word.rdata = mem[word_idx];
`ifdef DRAM_RANGE_CHK_EN
    if (out_of_range) begin
      rd_word.rdata = '0;
      rd_word.err   = 1'b1;
    end
`endif
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push_vld  = rd_acc;
      assign push_data = rd_word;
    end else begin : g_pipe
      localparam int STAGES = LATENCY - 1;
      logic [STAGES-1:0] vld_q;
      dram_resp_t        data_q [STAGES];

      // Valid shift register; reset drops every read still in flight.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= rd_acc;
          for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      // Data rides alongside its valid bit and is ignored where that is 0.
      always_ff @(posedge clk) begin
        data_q[0] <= rd_word;
        for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
      end

      assign push_vld  = vld_q[STAGES-1];
      assign push_data = data_q[STAGES-1];
    end
  endgenerate

  sync_fifo #(
    .WIDTH ($bits(dram_resp_t)),
    .DEPTH (OUTSTANDING)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push_vld),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (unused_fifo_full)
  );

  assign dram_data_ok = ~fifo_empty;
  assign pop          = dram_data_ok & dram_rready;

  // Credit counter: reads accepted but not yet popped.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (rd_acc && !pop) begin
      cnt <= cnt + CNT_W'(1);
    end else if (!rd_acc && pop) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Last word shown on rdata, replayed once the FIFO runs empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hold_q <= '0;
    end else if (!fifo_empty) begin
      hold_q <= head.rdata;
    end
  end

  assign dram_rdata = fifo_empty ? hold_q : head.rdata;
`ifdef DRAM_RANGE_CHK_EN
  assign dram_err   = ~fifo_empty & head.err;
`endif

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder. A reference model (word array plus
// a queue of pending responses stamped with their due cycle) predicts addr_ok,
// data_ok, rdata and err every cycle; scenario tasks add direct checks.
// Define DRAM_RANGE_CHK_EN for both bench and RTL to cover range checking.
`timescale 1ns/1ps
module tb_dram_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int OUT   = 3;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        dram_req;
  logic        dram_write;
  logic [3:0]  dram_wstrb;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_addr_ok;
  logic        dram_data_ok;
  logic [31:0] dram_rdata;
  logic        dram_rready;
`ifdef DRAM_RANGE_CHK_EN
  logic        dram_err;
`endif

  always #5 clk = ~clk;

  dram_responder #(
    .DEPTH       (DEPTH),
    .LATENCY     (LAT),
    .OUTSTANDING (OUT)
  ) dut (
`ifdef DRAM_RANGE_CHK_EN
    .dram_err     (dram_err),
`endif
    .clk          (clk),
    .rst_b        (rst_b),
    .dram_req     (dram_req),
    .dram_write   (dram_write),
    .dram_wstrb   (dram_wstrb),
    .dram_addr    (dram_addr),
    .dram_wdata   (dram_wdata),
    .dram_addr_ok (dram_addr_ok),
    .dram_data_ok (dram_data_ok),
    .dram_rdata   (dram_rdata),
    .dram_rready  (dram_rready)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } resp_t;

  resp_t       exp_q[$];     // model: reads accepted, not yet popped
  resp_t       popped_q[$];  // observed DUT responses taken by the bench
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_m;
  int          cyc;
  int          n_assert;
  int          n_fail;
  logic        obs_addr_ok;
  logic        obs_data_ok;
  logic [31:0] obs_rdata;
  logic        acc_m;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic oor(input logic [31:0] a);
`ifdef DRAM_RANGE_CHK_EN
    return a >= 32'(DEPTH * 4);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cycle(input logic req, input logic wr, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rdy);
    logic        exp_addr_ok;
    logic        exp_data_ok;
    logic [31:0] exp_rdata;
    resp_t       r;
    @(negedge clk);
    dram_req    = req;
    dram_write  = wr;
    dram_wstrb  = strb;
    dram_addr   = addr;
    dram_wdata  = wdata;
    dram_rready = rdy;
    #1;
    obs_addr_ok = dram_addr_ok;
    obs_data_ok = dram_data_ok;
    obs_rdata   = dram_rdata;
    exp_addr_ok = req && (wr || exp_q.size() < OUT);
    exp_data_ok = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    exp_rdata   = exp_data_ok ? exp_q[0].data : last_m;
    n_assert++;
    if (obs_addr_ok !== exp_addr_ok) begin
      n_fail++;
      $display("FAIL addr_ok cyc=%0d got=%b exp=%b", cyc, obs_addr_ok, exp_addr_ok);
    end
    n_assert++;
    if (obs_data_ok !== exp_data_ok) begin
      n_fail++;
      $display("FAIL data_ok cyc=%0d got=%b exp=%b", cyc, obs_data_ok, exp_data_ok);
    end
    n_assert++;
    if (obs_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, obs_rdata, exp_rdata);
    end
`ifdef DRAM_RANGE_CHK_EN
    n_assert++;
    if (dram_err !== (exp_data_ok ? exp_q[0].err : 1'b0)) begin
      n_fail++;
      $display("FAIL err cyc=%0d got=%b exp=%b", cyc, dram_err,
               exp_data_ok ? exp_q[0].err : 1'b0);
    end
    r.err = dram_err;
`else
    r.err = 1'b0;
`endif
    if (obs_data_ok && rdy) begin
      r.data = obs_rdata;
      r.due  = cyc;
      popped_q.push_back(r);
    end
    // Model update for the coming clock edge.
    if (exp_data_ok && rdy) begin
      last_m = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    acc_m = exp_addr_ok;
    if (exp_addr_ok && wr) begin
      if (!oor(addr)) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mem_m[widx(addr)][8*b +: 8] = wdata[8*b +: 8];
      end
    end else if (exp_addr_ok) begin
      r.data = oor(addr) ? 32'h0 : mem_m[widx(addr)];
      r.err  = oor(addr);
      r.due  = cyc + LAT;
      exp_q.push_back(r);
    end
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) idle(1'b1);
  endtask

  task automatic expect_bit(input string name, input logic got, input logic exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic expect_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    dram_req = 1'b0; dram_write = 1'b0; dram_wstrb = '0;
    dram_addr = '0; dram_wdata = '0; dram_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_bit("reset_addr_ok", dram_addr_ok, 1'b0);
    expect_bit("reset_data_ok", dram_data_ok, 1'b0);
    expect_word("reset_rdata", dram_rdata, 32'h0);
`ifdef DRAM_RANGE_CHK_EN
    expect_bit("reset_err", dram_err, 1'b0);
`endif
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // Give every word a known value so later reads never see undefined data.
  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b1);
  endtask

  task automatic test_byte_write();
    cycle(1'b1, 1'b1, 4'hF,    32'h10, 32'h11223344, 1'b1);
    cycle(1'b1, 1'b1, 4'b0100, 32'h12, 32'hAAAAAAAA, 1'b1);
    cycle(1'b1, 1'b0, 4'h0,    32'h10, 32'h0,        1'b1);
    expect_bit("byte_read_addr_ok", obs_addr_ok, 1'b1);
    for (int i = 1; i < LAT; i++) idle(1'b1);
    idle(1'b1);
    expect_bit("byte_read_data_ok", obs_data_ok, 1'b1);
    expect_word("byte_read_rdata", obs_rdata, 32'h11AA3344);
    drain();
  endtask

  task automatic test_back_to_back();
    int run;
    int best;
    int total;
    run = 0; best = 0; total = 0;
    for (int i = 0; i < 4 + 2 * LAT + 2; i++) begin
      if (i < 4) cycle(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0, 1'b1);
      else       idle(1'b1);
      if (obs_data_ok) begin
        run++; total++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    n_assert++;
    if (best != 4 || total != 4) begin
      n_fail++;
      $display("FAIL b2b_stream run=%0d total=%0d exp=4", best, total);
    end
    drain();
  endtask

  task automatic test_rw_order();
    logic [31:0] old_v;
    old_v = $urandom;
    cycle(1'b1, 1'b1, 4'hF, 32'h20, old_v, 1'b1);
    popped_q.delete();
    cycle(1'b1, 1'b0, 4'h0, 32'h20, 32'h0,        1'b1);
    cycle(1'b1, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 32'h20, 32'h0,        1'b1);
    for (int i = 0; i < 3 * LAT + 4; i++) idle(1'b1);
    n_assert++;
    if (popped_q.size() != 2) begin
      n_fail++;
      $display("FAIL rw_order_count got=%0d exp=2", popped_q.size());
    end else begin
      expect_word("rw_order_old", popped_q[0].data, old_v);
      expect_word("rw_order_new", popped_q[1].data, 32'hDEADBEEF);
    end
  endtask

  task automatic test_backpressure();
    int issued;
    int dut_acc;
    issued = 0; dut_acc = 0;
    for (int i = 0; i < OUT + LAT + 2; i++) begin
      cycle(1'b1, 1'b0, 4'h0, 32'h100 + 32'(issued * 4), 32'h0, 1'b0);
      if (acc_m) issued++;
      if (obs_addr_ok) dut_acc++;
    end
    n_assert++;
    if (dut_acc != OUT) begin
      n_fail++;
      $display("FAIL bp_accepts got=%0d exp=%0d", dut_acc, OUT);
    end
    cycle(1'b1, 1'b0, 4'h0, 32'h100 + 32'(issued * 4), 32'h0, 1'b1);
    expect_bit("bp_pop_cycle_addr_ok", obs_addr_ok, 1'b0);
    if (acc_m) issued++;
    cycle(1'b1, 1'b0, 4'h0, 32'h100 + 32'(issued * 4), 32'h0, 1'b0);
    expect_bit("bp_after_pop_addr_ok", obs_addr_ok, 1'b1);
    drain();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
`ifdef DRAM_RANGE_CHK_EN
      a = ($urandom_range(0, 7) == 0) ? $urandom
                                      : 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
`else
      a = $urandom;
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), a,
            $urandom, $urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int          stale;
    v = $urandom;
    cycle(1'b1, 1'b1, 4'hF, 32'h40, v, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    expect_bit("mid_pre_reset_data_ok", dram_data_ok,
               (exp_q.size() > 0) && (exp_q[0].due <= cyc));
    dram_req = 1'b0;
    rst_b    = 1'b0;
    #1;
    expect_bit("mid_reset_data_ok", dram_data_ok, 1'b0);
    expect_bit("mid_reset_addr_ok", dram_addr_ok, 1'b0);
    expect_word("mid_reset_rdata", dram_rdata, 32'h0);
    exp_q.delete();
    last_m = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    stale = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      idle(1'b1);
      if (obs_data_ok) stale++;
    end
    n_assert++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL mid_reset_stale got=%0d exp=0", stale);
    end
    popped_q.delete();
    cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1);
    drain();
    n_assert++;
    if (popped_q.size() != 1 || popped_q[0].data !== v) begin
      n_fail++;
      $display("FAIL mid_reset_mem_kept got=%h n=%0d exp=%h",
               popped_q.size() > 0 ? popped_q[0].data : 32'h0, popped_q.size(), v);
    end
  endtask

`ifdef DRAM_RANGE_CHK_EN
  task automatic test_range();
    logic [31:0] w0;
    logic [31:0] wtop;
    w0   = mem_m[0];
    wtop = mem_m[DEPTH - 1];
    popped_q.delete();
    cycle(1'b1, 1'b1, 4'hF, 32'h1000, 32'h55AA55AA, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 32'h0FFC, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 32'h0000, 32'h0, 1'b1);
    drain();
    n_assert++;
    if (popped_q.size() != 3) begin
      n_fail++;
      $display("FAIL range_count got=%0d exp=3", popped_q.size());
    end else begin
      expect_word("range_oor_rdata", popped_q[0].data, 32'h0);
      expect_bit("range_oor_err", popped_q[0].err, 1'b1);
      expect_word("range_top_rdata", popped_q[1].data, wtop);
      expect_bit("range_top_err", popped_q[1].err, 1'b0);
      expect_word("range_word0_kept", popped_q[2].data, w0);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    last_m   = 32'h0;
    test_reset();
    test_fill();
    test_byte_write();
    test_back_to_back();
    test_rw_order();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef DRAM_RANGE_CHK_EN
    test_range();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
